// File: rtl/if_prefetch_buffer_if.sv
// Bus bundle for the instruction prefetch buffer: the memory request side and the IF hand-off side.
// The master modport is the prefetch buffer. The slave modport is the memory and IF stage pair.
interface if_prefetch_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    output mem_req, mem_addr, if_valid, if_instr, if_pc, if_pc4,
    input  mem_ack, mem_rdata, if_ready
  );

  modport slave (
    input  mem_req, mem_addr, if_valid, if_instr, if_pc, if_pc4,
    output mem_ack, mem_rdata, if_ready
  );
endinterface

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: keeps one memory fetch in flight and queues returned words in a small FIFO.
// It presents {instr, pc, pc+4} to IF. A redirect flushes the queue and discards the in-flight word.
module if_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  if_prefetch_buffer_if.master       bus
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_W = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_instr_d [DEPTH];
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_pc_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          if_valid_q, if_valid_d;
  logic [31:0]   if_instr_q, if_instr_d;
  logic [31:0]   if_pc_q, if_pc_d;
  logic [31:0]   if_pc4_q, if_pc4_d;
  logic          push, pop;
  logic [31:0]   redirect_addr;

  assign redirect_addr = redirect_pc & 32'hFFFF_FFFC;
  assign pop           = (count_q != {CW{1'b0}}) && bus.if_ready;
  // Words returning during DISCARD or alongside a redirect belong to the old stream.
  assign push          = (state_q == REQ) && bus.mem_ack && !redirect;

  // FIFO storage, pointers and occupancy
  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    if (redirect) begin
      wptr_d  = {AW{1'b0}};
      rptr_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push) begin
        fifo_instr_d[wptr_q] = bus.mem_rdata;
        fifo_pc_d[wptr_q]    = mem_addr_q;
        wptr_d               = wptr_q + AW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Next head of the FIFO, which includes a word being pushed into an empty queue
  always_comb begin
    if_valid_d = (count_d != {CW{1'b0}});
    if_instr_d = 32'h0;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if (if_valid_d) begin
      if_instr_d = fifo_instr_d[rptr_d];
      if_pc_d    = fifo_pc_d[rptr_d];
      if_pc4_d   = fifo_pc_d[rptr_d] + 32'd4;
    end else begin
      if_instr_d = 32'h0;
    end
  end

  // Fetch FSM: request issue, completion and discard of a flushed fetch
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_addr;
        end else if (count_d < DEPTH_W) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_addr;
          if (bus.mem_ack) begin
            mem_addr_d = redirect_addr;
          end else begin
            state_d = DISCARD;
          end
        end else if (bus.mem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_d < DEPTH_W) begin
            mem_addr_d = fetch_pc_q + 32'd4;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end else begin
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redirect_addr;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (bus.mem_ack) begin
          state_d    = REQ;
          mem_addr_d = redirect ? redirect_addr : fetch_pc_q;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      wptr_q     <= {AW{1'b0}};
      rptr_q     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      if_pc4_q   <= 32'd4;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
    end
  end

  // FIFO payload needs no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_pc4   = if_pc4_q;

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: a latency-programmable memory model, a scoreboard of expected IF words,
// a per-cycle vector table for fill/stall/drain, and hand-written redirect and reset sequences.
module tb_if_prefetch_buffer;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;

  if_prefetch_buffer_if bus();

  if_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] pop_log[$];
  logic [31:0] exp_fetch;
  vec_t        vecs[16];
  int          errors;
  int          checks;
  int          mem_lat;
  int          lat_cnt;
  logic        ack_seen;
  logic        req_seen;
  logic        found;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got pc %h instr %h with no word expected", bus.if_pc, bus.if_instr);
    end else begin
      e = exp_q.pop_front();
      if (bus.if_instr !== e.instr || bus.if_pc !== e.pc || bus.if_pc4 !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL sb_entry: got instr %h pc %h pc4 %h expected instr %h pc %h pc4 %h",
                 bus.if_instr, bus.if_pc, bus.if_pc4, e.instr, e.pc, e.pc + 32'd4);
      end
    end
    pop_log.push_back(bus.if_pc);
  endtask

  // One clock: memory response, scoreboard update, edge, then settle 1 time unit past the edge.
  task automatic cycle();
    if (bus.mem_req === 1'b1 && lat_cnt >= mem_lat) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rom(bus.mem_addr);
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
    end
    if (!reset && !redirect && bus.if_valid === 1'b1 && bus.if_ready) sb_pop();
    if (reset) begin
      exp_q.delete();
      exp_fetch = 32'h0;
    end else if (redirect) begin
      exp_q.delete();
      exp_fetch = redirect_pc & 32'hFFFF_FFFC;
    end else if (bus.mem_ack && bus.mem_addr === exp_fetch) begin
      exp_q.push_back('{instr: rom(exp_fetch), pc: exp_fetch});
      exp_fetch = exp_fetch + 32'd4;
    end
    ack_seen = bus.mem_ack;
    req_seen = (bus.mem_req === 1'b1);
    @(posedge clk);
    #1;
    if (reset || ack_seen || !req_seen) lat_cnt = 0;
    else lat_cnt++;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    errors       = 0;
    checks       = 0;
    lat_cnt      = 0;
    mem_lat      = 0;
    exp_fetch    = 32'h0;
    reset        = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    bus.mem_ack  = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.if_ready = 1'b0;

    // Reset, fill with IF stalled (immediate acks), hold full, then drain with no gap.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h8,  1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 32'h0};
    for (int i = 6; i < 12; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 32'hC, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    for (int i = 0; i < 16; i++) begin
      reset        = vecs[i].rst;
      bus.if_ready = vecs[i].rdy;
      cycle();
      chk($sformatf("vec%0d {req,addr,valid,pc,instr}", i),
          {bus.mem_req, bus.mem_addr, bus.if_valid, bus.if_pc, bus.if_instr},
          {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc,
           (vecs[i].e_valid ? rom(vecs[i].e_pc) : 32'h0)});
      if (i == 1) chk("reset_pc4", bus.if_pc4, 32'd4);
    end

    // Ack one cycle after each request, IF always ready.
    mem_lat      = 1;
    bus.if_ready = 1'b1;
    do_reset();
    pop_log.delete();
    for (int i = 0; i < 40 && pop_log.size() < 4; i++) cycle();
    chk("t1_pop_count", 32'(pop_log.size() >= 4), 32'd1);
    if (pop_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("t1_pc%0d", k), pop_log[k], 32'(k * 4));
    end

    // Redirect while the fetch of 0x8 waits three more cycles for its ack.
    mem_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h8) found = 1'b1;
      else cycle();
    end
    chk("t3_fetch8_seen", found, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    cycle();
    redirect = 1'b0;
    chk("t3_old_req_held", {bus.mem_req, bus.mem_addr, bus.if_valid}, {1'b1, 32'h8, 1'b0});
    for (int i = 0; i < 20 && bus.mem_addr === 32'h8; i++) cycle();
    chk("t3_next_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h40});
    for (int i = 0; i < 20 && bus.if_valid !== 1'b1; i++) cycle();
    chk("t3_first_pc", {bus.if_valid, bus.if_pc}, {1'b1, 32'h40});

    // Redirect, ack and pop all in the same cycle.
    mem_lat = 0;
    do_reset();
    cycle();
    cycle();
    chk("t4_pre_valid_req", {bus.if_valid, bus.mem_req}, 2'b11);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    cycle();
    redirect = 1'b0;
    chk("t4_flush", {bus.if_valid, bus.if_instr, bus.mem_req, bus.mem_addr},
        {1'b0, 32'h0, 1'b1, 32'h100});
    cycle();
    chk("t4_first_pc", {bus.if_valid, bus.if_pc}, {1'b1, 32'h100});

    // Misaligned redirect near the top of the address space; fetch address wraps to zero.
    do_reset();
    cycle();
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFB;
    cycle();
    redirect = 1'b0;
    chk("t5_addr0", {bus.mem_req, bus.mem_addr, bus.if_valid}, {1'b1, 32'hFFFF_FFF8, 1'b0});
    cycle();
    chk("t5_addr1", {bus.mem_addr, bus.if_pc}, {32'hFFFF_FFFC, 32'hFFFF_FFF8});
    cycle();
    chk("t5_addr2", bus.mem_addr, 32'h0);
    chk("t5_pc4_wrap", {bus.if_valid, bus.if_pc, bus.if_pc4}, {1'b1, 32'hFFFF_FFFC, 32'h0});

    // Reset in the middle of a request with two entries buffered.
    bus.if_ready = 1'b0;
    do_reset();
    cycle();
    cycle();
    cycle();
    chk("t6_pre", {bus.mem_req, bus.mem_addr, bus.if_valid, bus.if_pc}, {1'b1, 32'h8, 1'b1, 32'h0});
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_after_reset", {bus.mem_req, bus.if_valid, bus.mem_addr, bus.if_instr},
        {1'b0, 1'b0, 32'h0, 32'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
